// File: rtl/latch_seq_pkg.sv
// Shared types and defaults for the latch write sequencer.
package latch_seq_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, GATE, HOLD} seq_state_t;

  localparam int N_REQ_D       = 4;
  localparam int N_LATCH_D     = 4;
  localparam int DATA_W_D      = 8;
  localparam int GATE_CYCLES_D = 2;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first eligible request at or after ptr, wrapping.
module rr_arbiter
  import latch_seq_pkg::*;
#(
  parameter  int N_REQ = N_REQ_D,
  localparam int PW    = clog2_min1(N_REQ)
)(
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PW-1:0]    idx,
  output logic             valid
);
  logic [N_REQ-1:0] elig;
  assign elig = req & ~mask;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!valid && elig[(int'(ptr) + i) % N_REQ]) begin
        valid = 1'b1;
        grant[(int'(ptr) + i) % N_REQ] = 1'b1;
        idx   = PW'((int'(ptr) + i) % N_REQ);
      end
    end
  end
endmodule

// File: rtl/latch_write_sequencer.sv
// Arbitrates N_REQ writers onto a shared latch bank and sequences SETUP/GATE/HOLD
// so D is stable around every gate pulse. All outputs are registered.
module latch_write_sequencer
  import latch_seq_pkg::*;
#(
  parameter  int N_REQ       = N_REQ_D,
  parameter  int N_LATCH     = N_LATCH_D,
  parameter  int DATA_W      = DATA_W_D,
  parameter  int GATE_CYCLES = GATE_CYCLES_D,
  localparam int AW          = clog2_min1(N_LATCH),
  localparam int PW          = clog2_min1(N_REQ),
  localparam int CW          = clog2_min1(GATE_CYCLES)
)(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*AW-1:0]       addr,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
  output logic [N_REQ-1:0]          ack,
  output logic                      err,
  output logic [DATA_W-1:0]         latch_d,
  output logic [N_LATCH-1:0]        latch_g,
  output logic                      busy
);
  seq_state_t state, state_nxt;

  logic [N_REQ-1:0][AW-1:0]     addr_v;
  logic [N_REQ-1:0][DATA_W-1:0] wdata_v;
  assign addr_v  = addr;
  assign wdata_v = wdata;

  logic [PW-1:0]      ptr, ptr_nxt, win, win_nxt;
  logic [AW-1:0]      cap_addr, cap_addr_nxt;
  logic [CW-1:0]      gcnt, gcnt_nxt;
  logic [DATA_W-1:0]  d_nxt;
  logic [N_LATCH-1:0] g_nxt;
  logic [N_REQ-1:0]   ack_nxt;
  logic               err_nxt, addr_ok;

  logic [N_REQ-1:0] arb_mask, arb_grant;
  logic [PW-1:0]    arb_idx;
  logic             arb_valid;

  // In HOLD the finishing winner still holds req; keep it out of the next round.
  always_comb begin
    arb_mask = '0;
    if (state == HOLD) arb_mask[win] = 1'b1;
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (req),
    .mask  (arb_mask),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    win_nxt      = win;
    cap_addr_nxt = cap_addr;
    gcnt_nxt     = gcnt;
    d_nxt        = latch_d;
    g_nxt        = '0;
    ack_nxt      = '0;
    err_nxt      = 1'b0;

    case (state)
      SETUP: begin
        state_nxt = GATE;
        gcnt_nxt  = '0;
      end
      GATE: begin
        if (gcnt == CW'(GATE_CYCLES - 1)) state_nxt = HOLD;
        else                              gcnt_nxt  = gcnt + 1'b1;
      end
      default: begin // IDLE and HOLD both arbitrate
        state_nxt = IDLE;
        if (arb_valid) begin
          state_nxt    = SETUP;
          win_nxt      = arb_idx;
          cap_addr_nxt = addr_v[arb_idx];
          d_nxt        = wdata_v[arb_idx];
          ptr_nxt      = (arb_idx == PW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
        end
      end
    endcase

    // Outputs are decoded from the next state so they come straight from flops.
    addr_ok = int'(cap_addr_nxt) < N_LATCH;
    if (state_nxt == GATE && addr_ok) g_nxt[cap_addr_nxt] = 1'b1;
    if (state_nxt == HOLD) begin
      ack_nxt[win_nxt] = 1'b1;
      err_nxt          = !addr_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      win      <= '0;
      cap_addr <= '0;
      gcnt     <= '0;
      ack      <= '0;
      err      <= 1'b0;
      latch_d  <= '0;
      latch_g  <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      win      <= win_nxt;
      cap_addr <= cap_addr_nxt;
      gcnt     <= gcnt_nxt;
      ack      <= ack_nxt;
      err      <= err_nxt;
      latch_d  <= d_nxt;
      latch_g  <= g_nxt;
      busy     <= (state_nxt != IDLE);
    end
  end
endmodule
